// File: rtl/adc_sample_source_if.sv
// Bundles the ADC front end's SPI pins, enable and the sample stream handed to the filter chain.
// The master side is the front end that produces samples; the slave side is the ADC or consumer.
interface adc_sample_source_if;
    logic               enable_in;
    logic               miso_in;
    logic               cs_n_out;
    logic               sclk_out;
    logic signed [15:0] sample_out;
    logic               ready_out;
    logic               frame_err_out;

    modport master (
        input  enable_in,
        input  miso_in,
        output cs_n_out,
        output sclk_out,
        output sample_out,
        output ready_out,
        output frame_err_out
    );

    modport slave (
        output enable_in,
        output miso_in,
        input  cs_n_out,
        input  sclk_out,
        input  sample_out,
        input  ready_out,
        input  frame_err_out
    );
endinterface

// File: rtl/adc_sample_source.sv
// Periodic 16-SCLK SPI conversion of a 12-bit ADC code, mid-scale offset removed,
// delivered as a signed 16-bit sample with a one-cycle ready strobe.
module adc_sample_source #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2048,
    parameter int DC_OFFSET     = 2048
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    adc_sample_source_if.master  bus
);

    localparam int DATA_W = 16;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int CNT_W  = $clog2(SAMPLE_PERIOD);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Subtraction is done one bit wider so the offset cannot wrap before truncation.
    function automatic logic signed [DATA_W-1:0] remove_offset(input logic [11:0] code);
        logic signed [DATA_W:0] wide;
        wide = $signed({5'b0, code}) - $signed((DATA_W+1)'(DC_OFFSET));
        return wide[DATA_W-1:0];
    endfunction

    state_t                    state_q,     state_d;
    logic [CNT_W-1:0]          period_q,    period_d;
    logic [DIV_W-1:0]          div_q,       div_d;
    logic [3:0]                bit_q,       bit_d;
    logic [15:0]               raw_q,       raw_d;
    logic                      miso_p0_q,   miso_p0_d;
    logic                      miso_p1_q,   miso_p1_d;
    logic                      cs_n_q,      cs_n_d;
    logic                      sclk_q,      sclk_d;
    logic signed [DATA_W-1:0]  sample_q,    sample_d;
    logic                      ready_q,     ready_d;
    logic                      frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        div_d       = div_q;
        bit_d       = bit_q;
        raw_d       = raw_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        sample_d    = sample_q;
        ready_d     = 1'b0;
        frame_err_d = 1'b0;
        miso_p0_d   = bus.miso_in;
        miso_p1_d   = miso_p0_q;

        // The period counter free-runs except when parked in IDLE with conversions disabled.
        if ((state_q == ST_IDLE) && !bus.enable_in) begin
            period_d = '0;
        end else if (period_q == PERIOD_LAST) begin
            period_d = '0;
        end else begin
            period_d = period_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                if ((period_q == '0) && bus.enable_in) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                end
            end
            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = 4'd15;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        raw_d  = {raw_q[14:0], miso_p1_q};
                    end else if (bit_q == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q - 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                cs_n_d      = 1'b1;
                sclk_d      = 1'b1;
                ready_d     = 1'b1;
                frame_err_d = |raw_q[15:12];
                sample_d    = remove_offset(raw_q[11:0]);
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    // Register stage: FSM, counters, synchronizer and all outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            raw_q       <= '0;
            miso_p0_q   <= 1'b0;
            miso_p1_q   <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            sample_q    <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            raw_q       <= raw_d;
            miso_p0_q   <= miso_p0_d;
            miso_p1_q   <= miso_p1_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            sample_q    <= sample_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.cs_n_out      = cs_n_q;
    assign bus.sclk_out      = sclk_q;
    assign bus.sample_out    = sample_q;
    assign bus.ready_out     = ready_q;
    assign bus.frame_err_out = frame_err_q;

endmodule

// File: tb/tb_adc_sample_source.sv
// Directed bench for adc_sample_source with a behavioural serial ADC that shifts out
// a 16-bit word MSB first, changing data on each SCLK fall.
module tb_adc_sample_source;

    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 256;
    localparam int DC_OFFSET     = 2048;
    localparam int READY_CYCLE   = 2 + 33 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adc_sample_source_if bus ();

    adc_sample_source #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .DC_OFFSET     (DC_OFFSET)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ADC model: index rewinds whenever chip select is released.
    logic [15:0] adc_word = 16'h0000;
    int          adc_idx  = 15;

    always @(negedge bus.sclk_out or posedge bus.cs_n_out) begin
        if (bus.cs_n_out) begin
            adc_idx = 15;
        end else begin
            bus.miso_in = adc_word[adc_idx];
            if (adc_idx > 0) adc_idx = adc_idx - 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycle numbers follow the start-edge convention: the value seen after edge k is cycle k+1.
    task automatic wait_ready(input int start_cyc, output int at);
        int n;
        n  = start_cyc;
        at = -1;
        while ((at < 0) && (n < start_cyc + 600)) begin
            @(negedge clk);
            n++;
            if (bus.ready_out) at = n;
        end
    endtask

    task automatic wait_cs_low(output int found);
        int n;
        n     = 0;
        found = 0;
        while ((found == 0) && (n < 600)) begin
            @(negedge clk);
            n++;
            if (!bus.cs_n_out) found = 1;
        end
    endtask

    int at;
    int found;
    int activity;

    initial begin
        bus.enable_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n",      int'(bus.cs_n_out),          1);
        chk("rst_sclk",      int'(bus.sclk_out),          1);
        chk("rst_sample",    int'($signed(bus.sample_out)), 0);
        chk("rst_ready",     int'(bus.ready_out),         0);
        chk("rst_frame_err", int'(bus.frame_err_out),     0);

        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_no_start", int'(bus.cs_n_out), 1);

        // Frame 1: 0x0ABC -> 2748 - 2048 = 700
        adc_word = 16'h0ABC;
        bus.enable_in = 1'b1;
        @(negedge clk);
        chk("f1_cs_low_c1",  int'(bus.cs_n_out), 0);
        chk("f1_sclk_hi_c1", int'(bus.sclk_out), 1);
        repeat (CLK_DIV) @(negedge clk);
        chk("f1_sclk_fall",  int'(bus.sclk_out), 0);
        wait_ready(1 + CLK_DIV, at);
        chk("f1_ready_cycle", at, READY_CYCLE);
        chk("f1_sample",      int'($signed(bus.sample_out)), 700);
        chk("f1_frame_err",   int'(bus.frame_err_out), 0);
        chk("f1_cs_high",     int'(bus.cs_n_out), 1);
        @(negedge clk);
        chk("f1_ready_pulse", int'(bus.ready_out), 0);
        chk("f1_sample_hold", int'($signed(bus.sample_out)), 700);

        // Frame 2 follows one sample period after frame 1
        wait_ready(1, at);
        chk("f2_spacing", at, SAMPLE_PERIOD);
        chk("f2_sample",  int'($signed(bus.sample_out)), 700);

        adc_word = 16'h0000;
        wait_ready(0, at);
        chk("f3_spacing", at, SAMPLE_PERIOD);
        chk("f3_sample_min", int'($signed(bus.sample_out)), -2048);

        adc_word = 16'h0FFF;
        wait_ready(0, at);
        chk("f4_sample_max", int'($signed(bus.sample_out)), 2047);
        chk("f4_frame_err",  int'(bus.frame_err_out), 0);

        // Non-zero leading nibble flags a framing error but still yields the low 12 bits
        adc_word = 16'hFABC;
        wait_ready(0, at);
        chk("f5_sample",     int'($signed(bus.sample_out)), 700);
        chk("f5_frame_err",  int'(bus.frame_err_out), 1);
        @(negedge clk);
        chk("f5_err_pulse",  int'(bus.frame_err_out), 0);

        // Reset in the middle of a frame: 0x0123 -> 291 - 2048 = -1757 for the restarted frame
        adc_word = 16'h0123;
        wait_cs_low(found);
        chk("f6_start", found, 1);
        repeat (59) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs_n",   int'(bus.cs_n_out), 1);
        chk("mid_rst_sclk",   int'(bus.sclk_out), 1);
        chk("mid_rst_sample", int'($signed(bus.sample_out)), 0);
        chk("mid_rst_ready",  int'(bus.ready_out), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_start", int'(bus.cs_n_out), 0);
        wait_ready(1, at);
        chk("post_rst_ready_cycle", at, READY_CYCLE);
        chk("post_rst_sample", int'($signed(bus.sample_out)), -1757);

        // Enable dropped mid-frame: 0x0801 -> 1, frame still completes
        adc_word = 16'h0801;
        wait_cs_low(found);
        chk("f7_start", found, 1);
        repeat (49) @(negedge clk);
        bus.enable_in = 1'b0;
        wait_ready(50, at);
        chk("en_drop_ready_cycle", at, READY_CYCLE);
        chk("en_drop_sample", int'($signed(bus.sample_out)), 1);
        activity = 0;
        repeat (300) begin
            @(negedge clk);
            if (!bus.cs_n_out || bus.ready_out) activity++;
        end
        chk("en_low_quiet", activity, 0);

        // Re-enable: 0x07FF -> -1
        adc_word = 16'h07FF;
        bus.enable_in = 1'b1;
        @(negedge clk);
        chk("re_enable_start", int'(bus.cs_n_out), 0);
        wait_ready(1, at);
        chk("re_enable_ready_cycle", at, READY_CYCLE);
        chk("re_enable_sample", int'($signed(bus.sample_out)), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_sample_source.md
# adc_sample_source

SPI ADC front end that produces the sample stream the filter chain consumes. It periodically converts one 12-bit sample from an external serial ADC (16-SCLK frame, 4 leading zeros, MSB first). It removes a fixed mid-scale offset and presents a signed 16-bit sample with a one-cycle `ready_out` strobe. Downstream (`lowpass`, then the LMS path) takes `ready_out`/`sample_out` as its `ready_in`/`signal_in`. It replaces the file-driven stimulus used in simulation.

## Interface
- `CLK_DIV`, 4: clk cycles per SCLK half-period; legal range ≥ 3.
- `SAMPLE_PERIOD`, 2048: clk cycles between conversion starts; must be ≥ 33*`CLK_DIV` + 4.
- `DC_OFFSET`, 2048: value subtracted from the raw 12-bit code.
- `clk_in` in 1: system clock, 100 MHz.
- `rst_in` in 1: reset, synchronous, active-high.
- `enable_in` in 1: permits new conversions.
- `miso_in` in 1: ADC serial data (asynchronous to `clk_in`).
- `cs_n_out` out 1: ADC chip select, active low.
- `sclk_out` out 1: ADC serial clock, idles high.
- `sample_out` out 16 (signed): last converted sample.
- `ready_out` out 1: one-cycle strobe when `sample_out` updates.
- `frame_err_out` out 1: one-cycle strobe, coincident with `ready_out`, when the leading 4 bits were not zero.

## Operation
- `miso_in` passes through a 2-flop synchronizer before use. All outputs are registered.
- Period counter runs 0..`SAMPLE_PERIOD`-1 and wraps to 0.
  - While `enable_in` is low and the FSM is in IDLE, the counter is held at 0.
  - A conversion starts when the counter is 0, `enable_in` is high, and the FSM is in IDLE.
- State machine:
  - IDLE: `cs_n_out`=1, `sclk_out`=1. On start, go to SETUP.
  - SETUP: `cs_n_out`=0, `sclk_out`=1 for `CLK_DIV` cycles, then go to SHIFT with bit index 15.
  - SHIFT: 16 bits. For each bit, `sclk_out`=0 for `CLK_DIV` cycles, then 1 for `CLK_DIV` cycles.
    - The synchronized `miso_in` is shifted into a 16-bit raw register (MSB first) on the cycle `sclk_out` goes 0→1.
    - After the high phase of bit 0, go to DONE.
  - DONE (1 cycle): `cs_n_out`=1.
    - `sample_out` <= signed(`{4'b0, raw[11:0]}`) − `DC_OFFSET`, computed in 17 bits and truncated to 16. With default parameters the result lies in −2048..2047, so no overflow.
    - `ready_out`=1; `frame_err_out` = (raw[15:12] != 0).
    - Go to IDLE.
- Deasserting `enable_in` mid-conversion does not abort it. The frame completes and `ready_out` fires. No further starts occur until `enable_in` is high again.
- `sample_out` holds its value between strobes.
- Reset, including mid-conversion, takes effect at the next clock edge:
  - FSM to IDLE; counter, raw register and bit index to 0; synchronizer flops to 0.
  - `cs_n_out`=1, `sclk_out`=1, `sample_out`=0, `ready_out`=0, `frame_err_out`=0.
  - A partially shifted frame is discarded with no strobe.

## Timing
- Start edge (counter 0 in IDLE, `enable_in` high) = cycle 0. `cs_n_out` is low from cycle 1.
- First `sclk_out` fall at cycle 1+`CLK_DIV`.
- The `sclk_out` rise for bit *k* (k = 15..0) occurs at cycle 1+`CLK_DIV`*(2*(15−k)+2). The same cycle captures the synchronized `miso_in`, which is the pin value 2 cycles earlier.
  - The ADC changes data on the SCLK fall, so `CLK_DIV` ≥ 3 guarantees the captured value is stable.
- `ready_out` is high at cycle 2+33*`CLK_DIV` (defaults: cycle 134). `cs_n_out` returns high on the same cycle.
- Strobe rate with `enable_in` held high: exactly one per `SAMPLE_PERIOD` cycles. With the defaults this is 48.83 kHz.
- `cs_n_out` is high for at least `SAMPLE_PERIOD` − 33*`CLK_DIV` − 2 cycles between frames.

## Test plan
- Bench parameters: `CLK_DIV`=4, `SAMPLE_PERIOD`=256, `DC_OFFSET`=2048. The ADC model drives `miso_in` from a 16-bit word on each `sclk_out` fall.
- Model word 0x0ABC → `ready_out` high exactly 134 cycles after start, `sample_out`=+700, `frame_err_out`=0.
  - The next strobe comes 256 cycles after the first.
- Words 0x0000 then 0x0FFF on consecutive frames → `sample_out`=−2048 then +2047.
- Word 0xFABC → `sample_out`=+700 with `frame_err_out` high for one cycle together with `ready_out`.
- Reset pulsed at cycle 60 of a frame → next cycle `cs_n_out`=1, `sclk_out`=1, `sample_out`=0. No `ready_out` for the aborted frame.
  - The next frame starts at counter 0 after release.
- `enable_in` dropped at cycle 50 of a frame → that frame completes with `ready_out` at cycle 134. No further `cs_n_out` activity while low.
  - Re-raising `enable_in` starts a frame on the following cycle.
